// File: rtl/seg7_pkg.sv
// Shared constants for the active-low seven-segment display path ({G,F,E,D,C,B,A}, A in bit 0).
// Also holds the one-cold anode index helper used by the scan monitors.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_IDLE   = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Position of the low bit in an active-low anode vector; meaningful only when exactly one bit is low.
  function automatic logic [2:0] low_index(input logic [7:0] an_n);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: pattern -> {nibble, is_hex, is_blank}.
// Zero latency; non-hex patterns report nibble 0.
import seg7_pkg::*;

module seg7_pattern_decode (
  input  logic [6:0] pattern,
  output nibble_t    nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble   = '0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: begin
        is_hex   = 1'b0;
        is_blank = (pattern == SEG_BLANK);
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Scanned seven-segment bus monitor: glitch-filters {an,seg}, decodes each stable digit into an 8-digit frame.
// Updates land STABLE_CYCLES edges after a new value is first sampled; input-only, no backpressure.
import seg7_pkg::*;

module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [7:0]  an,
  output logic [31:0] digits,
  output logic [7:0]  valid,
  output logic [7:0]  blank,
  output logic [7:0]  err,
  output logic        frame_done,
  output logic        multi_an
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

  logic [14:0] cur;
  logic [14:0] smp;
  logic [7:0]  cnt;
  logic        same;
  logic        capture;
  logic [7:0]  an_act;
  logic        any_an;
  logic        one_an;
  logic [2:0]  idx;
  logic [7:0]  seen;
  logic [7:0]  seen_upd;
  nibble_t     dec_nibble;
  logic        dec_hex;
  logic        dec_blank;

  assign cur    = {an, seg};
  assign same   = (cur == smp);
  // cnt saturates, so the fire point is crossed exactly once per stable period.
  assign capture = same && (cnt == CNT_FIRE);

  assign an_act   = ~an;
  assign any_an   = (an != AN_IDLE);
  assign one_an   = any_an && ((an_act & (an_act - 8'd1)) == 8'd0);
  assign idx      = low_index(an);
  assign seen_upd = seen | (8'd1 << idx);

  seg7_pattern_decode u_decode (
    .pattern  (seg),
    .nibble   (dec_nibble),
    .is_hex   (dec_hex),
    .is_blank (dec_blank)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= {AN_IDLE, SEG_BLANK};
      cnt <= '0;
    end else begin
      smp <= cur;
      if (!same) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= '0;
      valid      <= '0;
      blank      <= '0;
      err        <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      multi_an   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      multi_an   <= 1'b0;
      if (capture && any_an) begin
        if (!one_an) begin
          multi_an <= 1'b1;
        end else begin
          digits[{idx, 2'b00} +: 4] <= dec_nibble;
          valid[idx] <= dec_hex;
          blank[idx] <= dec_blank;
          err[idx]   <= !dec_hex && !dec_blank;
          if (seen_upd == 8'hFF) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_upd;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES=4; pulses are tallied on the falling edge.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [31:0] digits;
  logic [7:0]  valid, blank, err;
  logic        frame_done, multi_an;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int ma_cnt = 0;

  seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .valid      (valid),
    .blank      (blank),
    .err        (err),
    .frame_done (frame_done),
    .multi_an   (multi_an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (multi_an === 1'b1) ma_cnt++;
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Drive a value just after an edge and let n rising edges sample it.
  task automatic show(input logic [7:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 8'($urandom);
    seg = 7'($urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    an  = 8'hFF;
    seg = 7'h7F;
    checks++; if (digits !== 32'h0) begin failures++; $display("FAIL reset_digits: got %h expected %h", digits, 32'h0); end
    checks++; if ({valid, blank, err} !== 24'h0) begin failures++; $display("FAIL reset_status: got %h expected %h", {valid, blank, err}, 24'h0); end
    checks++; if ({frame_done, multi_an} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b expected %b", {frame_done, multi_an}, 2'b00); end
    show(8'hFF, 7'h7F, 6);
    checks++; if (fd_cnt + ma_cnt !== 0) begin failures++; $display("FAIL reset_no_pulse: got %0d expected %0d", fd_cnt + ma_cnt, 0); end
  endtask

  task automatic test_single_digit();
    show(8'hFE, 7'h24, 4);
    checks++; if (valid !== 8'h00) begin failures++; $display("FAIL single_early: got %h expected %h", valid, 8'h00); end
    show(8'hFE, 7'h24, 1);
    checks++; if (digits[3:0] !== 4'h2) begin failures++; $display("FAIL single_nibble: got %h expected %h", digits[3:0], 4'h2); end
    checks++; if (valid !== 8'h01) begin failures++; $display("FAIL single_valid: got %h expected %h", valid, 8'h01); end
    show(8'hFE, 7'h24, 1);
    show(8'hFF, 7'h7F, 3);
    checks++; if (fd_cnt !== 0) begin failures++; $display("FAIL single_no_frame: got %0d expected %0d", fd_cnt, 0); end
  endtask

  task automatic test_glitch();
    show(8'hFD, 7'h30, 3);
    show(8'hFF, 7'h7F, 6);
    show(8'hFD, 7'h30, 4);
    show(8'hFF, 7'h7F, 6);
    checks++; if (digits !== 32'h0000_0002) begin failures++; $display("FAIL glitch_digits: got %h expected %h", digits, 32'h0000_0002); end
    checks++; if (valid !== 8'h01) begin failures++; $display("FAIL glitch_valid: got %h expected %h", valid, 8'h01); end
  endtask

  task automatic test_full_scan();
    int fd0;
    fd0 = fd_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        show(~(8'd1 << i), hex_seg(4'(i + 1)), 5);
        if (i == 7) begin
          checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL scan_pulse: got %b expected %b", frame_done, 1'b1); end
        end
      end
      show(8'hFF, 7'h7F, 3);
    end
    checks++; if (digits !== 32'h8765_4321) begin failures++; $display("FAIL scan_digits: got %h expected %h", digits, 32'h8765_4321); end
    checks++; if (valid !== 8'hFF) begin failures++; $display("FAIL scan_valid: got %h expected %h", valid, 8'hFF); end
    checks++; if (fd_cnt - fd0 !== 2) begin failures++; $display("FAIL scan_frame_count: got %0d expected %0d", fd_cnt - fd0, 2); end
  endtask

  task automatic test_illegal_blank();
    show(8'hFB, 7'h55, 5);
    checks++; if (err !== 8'h04) begin failures++; $display("FAIL illegal_err: got %h expected %h", err, 8'h04); end
    checks++; if (digits[11:8] !== 4'h0) begin failures++; $display("FAIL illegal_nibble: got %h expected %h", digits[11:8], 4'h0); end
    checks++; if (valid !== 8'hFB) begin failures++; $display("FAIL illegal_valid: got %h expected %h", valid, 8'hFB); end
    show(8'hF7, 7'h7F, 5);
    checks++; if (blank !== 8'h08) begin failures++; $display("FAIL blank_mask: got %h expected %h", blank, 8'h08); end
    checks++; if (valid !== 8'hF3) begin failures++; $display("FAIL blank_valid: got %h expected %h", valid, 8'hF3); end
    checks++; if (digits !== 32'h8765_0021) begin failures++; $display("FAIL blank_digits: got %h expected %h", digits, 32'h8765_0021); end
    checks++; if (err !== 8'h04) begin failures++; $display("FAIL blank_err: got %h expected %h", err, 8'h04); end
    show(8'hFF, 7'h7F, 3);
  endtask

  task automatic test_multi_anode_reset();
    int ma0;
    int fd0;
    logic [3:0] order [8];
    order = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3};
    ma0 = ma_cnt;
    show(8'hFC, 7'h40, 10);
    show(8'hFF, 7'h7F, 2);
    checks++; if (ma_cnt - ma0 !== 1) begin failures++; $display("FAIL multi_count: got %0d expected %0d", ma_cnt - ma0, 1); end
    checks++; if (digits !== 32'h8765_0021) begin failures++; $display("FAIL multi_digits: got %h expected %h", digits, 32'h8765_0021); end
    show(8'hFE, 7'h10, 5);
    show(8'hFD, 7'h08, 5);
    show(8'hFB, 7'h03, 5);
    checks++; if (digits[11:0] !== 12'hBA9) begin failures++; $display("FAIL pre_reset_digits: got %h expected %h", digits[11:0], 12'hBA9); end
    rst = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if ({digits, valid, blank, err} !== 56'h0) begin failures++; $display("FAIL midframe_reset: got %h expected %h", {digits, valid, blank, err}, 56'h0); end
    fd0 = fd_cnt;
    for (int k = 0; k < 8; k++) begin
      show(~(8'd1 << order[k]), hex_seg(4'(order[k] + 1)), 5);
      if (k == 3) begin
        checks++; if (fd_cnt !== fd0 || frame_done !== 1'b0) begin failures++; $display("FAIL stale_seen: got %0d expected %0d", fd_cnt - fd0 + int'(frame_done), 0); end
      end
    end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL post_reset_frame: got %b expected %b", frame_done, 1'b1); end
    show(8'hFF, 7'h7F, 3);
    checks++; if (digits !== 32'h8765_4321) begin failures++; $display("FAIL post_reset_digits: got %h expected %h", digits, 32'h8765_4321); end
    checks++; if (fd_cnt - fd0 !== 1) begin failures++; $display("FAIL post_reset_count: got %0d expected %0d", fd_cnt - fd0, 1); end
  endtask

  initial begin
    rst = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    test_reset();
    test_single_digit();
    test_glitch();
    test_full_scan();
    test_illegal_blank();
    test_multi_anode_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
